// File: rtl/event_byte_serializer.sv
// event_byte_serializer
//
// Takes filtered DVS events (16-bit x, y, t plus polarity), one per clock
// with no back-pressure. Events are buffered in a small FIFO. Each event
// leaves as a 7-byte frame on an 8-bit valid/ready byte stream.
// Events that arrive while the FIFO is full are dropped, and the drop
// counter saturates at 255.
//
// Frame layout:
//   {SYNC[7:1], p}, x[15:8], x[7:0], y[15:8], y[7:0], t[15:8], t[7:0]
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   ev_valid              event present this cycle (no ready returned)
//   ev_x, ev_y, ev_t      16-bit event fields
//   ev_p                  event polarity
//   out_data              current frame byte (registered)
//   out_valid             out_data is valid (registered)
//   out_ready             downstream accepts the byte
//   out_last              out_data is the final byte of the frame (registered)
//   fifo_level            occupied FIFO entries, 0..DEPTH (registered)
//   drop_count            saturating count of dropped events (registered)

module event_byte_serializer #(
    parameter int          DEPTH = 4,
    parameter logic [7:0]  SYNC  = 8'hA0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ev_valid,
    input  logic [15:0]                ev_x,
    input  logic [15:0]                ev_y,
    input  logic [15:0]                ev_t,
    input  logic                       ev_p,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [7:0]                 drop_count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          r_state;
    logic [2:0]      r_idx;
    logic [48:0]     r_frame;
    logic [7:0]      r_outData;
    logic            r_outValid;
    logic            r_outLast;

    logic [48:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_level;
    logic [7:0]      r_dropCount;

    logic            w_empty;
    logic            w_full;
    logic            w_lastHs;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [48:0]     w_head;
    logic [48:0]     w_evWord;

    // Select one byte of a {p, x, y, t} frame word by its position in the frame.
    function automatic logic [7:0] byteSel(input logic [48:0] f, input logic [2:0] k);
        logic [7:0] b;
        b = 8'h00;
        case (k)
            3'd0:    b = {SYNC[7:1], f[48]};
            3'd1:    b = f[47:40];
            3'd2:    b = f[39:32];
            3'd3:    b = f[31:24];
            3'd4:    b = f[23:16];
            3'd5:    b = f[15:8];
            3'd6:    b = f[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LVL_FULL);
    assign w_head   = r_mem[r_rptr];
    assign w_evWord = {ev_p, ev_x, ev_y, ev_t};

    // A pop happens when the FSM loads a frame. It loads either from IDLE or
    // right on the last-byte handshake, so back-to-back frames have no bubble.
    // A pop in the same cycle frees a slot, so a push can be accepted even
    // when the FIFO is full.
    assign w_lastHs = (r_state == SEND) && out_ready && (r_idx == 3'd6);
    assign w_pop    = !w_empty && ((r_state == IDLE) || w_lastHs);
    assign w_push   = ev_valid && (!w_full || w_pop);
    assign w_drop   = ev_valid && w_full && !w_pop;

    // FIFO storage. It has no reset because occupancy is tracked by the
    // pointers and level alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_evWord;
        end
    end

    // FIFO pointers, occupancy and drop counter. The pointers wrap modulo DEPTH.
    // The extra level bit tells full apart from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_dropCount <= 8'h00;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_dropCount != 8'hFF)) begin
                r_dropCount <= r_dropCount + 8'd1;
            end
        end
    end

    // Frame FSM. The next byte is computed ahead and registered, so every
    // output comes straight from a flop. While out_ready is low in SEND,
    // nothing here changes, which keeps the presented byte stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= 3'd0;
            r_frame    <= '0;
            r_outData  <= 8'h00;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state    <= SEND;
                        r_frame    <= w_head;
                        r_idx      <= 3'd0;
                        r_outData  <= byteSel(w_head, 3'd0);
                        r_outValid <= 1'b1;
                        r_outLast  <= 1'b0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (r_idx == 3'd6) begin
                            if (w_pop) begin
                                r_frame    <= w_head;
                                r_idx      <= 3'd0;
                                r_outData  <= byteSel(w_head, 3'd0);
                                r_outLast  <= 1'b0;
                            end else begin
                                r_state    <= IDLE;
                                r_idx      <= 3'd0;
                                r_outData  <= 8'h00;
                                r_outValid <= 1'b0;
                                r_outLast  <= 1'b0;
                            end
                        end else begin
                            r_idx     <= r_idx + 3'd1;
                            r_outData <= byteSel(r_frame, r_idx + 3'd1);
                            r_outLast <= (r_idx == 3'd5);
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                    r_outLast  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data   = r_outData;
    assign out_valid  = r_outValid;
    assign out_last   = r_outLast;
    assign fifo_level = r_level;
    assign drop_count = r_dropCount;

endmodule

// File: tb/tb_event_byte_serializer.sv
// tb_event_byte_serializer
//
// Directed testbench for event_byte_serializer with DEPTH=4 and SYNC=8'hA0.
// Inputs are driven 1 time unit after each rising edge. Outputs are
// checked at that same point, so each check sees the state left by the
// edge just taken.

module tb_event_byte_serializer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        evValid;
    logic [15:0] evX;
    logic [15:0] evY;
    logic [15:0] evT;
    logic        evP;
    logic [7:0]  outData;
    logic        outValid;
    logic        outReady;
    logic        outLast;
    logic [2:0]  fifoLevel;
    logic [7:0]  dropCount;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  t1Exp [7];
    logic [15:0] e3X [3];
    logic [15:0] e3Y [3];
    logic [15:0] e3T [3];
    logic        e3P [3];
    logic [15:0] ovX [10];
    logic [15:0] ovY [10];
    logic [15:0] ovT [10];
    logic        ovP [10];
    int          modelIdx;
    int          cyc;
    logic        rdy;
    int          f;

    event_byte_serializer #(
        .DEPTH (4),
        .SYNC  (8'hA0)
    ) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .ev_valid   (evValid),
        .ev_x       (evX),
        .ev_y       (evY),
        .ev_t       (evT),
        .ev_p       (evP),
        .out_data   (outData),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_last   (outLast),
        .fifo_level (fifoLevel),
        .drop_count (dropCount)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Advance one rising edge, then settle just past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] x, input logic [15:0] y,
                                 input logic [15:0] t, input logic p, input logic rd);
        evValid  = v;
        evX      = x;
        evY      = y;
        evT      = t;
        evP      = p;
        outReady = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference frame layout: header {A0[7:1], p}, then x, y, t most-significant byte first.
    function automatic logic [7:0] frameByte(input logic [15:0] x, input logic [15:0] y,
                                             input logic [15:0] t, input logic p, input int k);
        logic [7:0] b;
        case (k)
            0:       b = {7'b1010000, p};
            1:       b = x[15:8];
            2:       b = x[7:0];
            3:       b = y[15:8];
            4:       b = y[7:0];
            5:       b = t[15:8];
            6:       b = t[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    task automatic checkFrameByte(input string tag, input logic [15:0] x, input logic [15:0] y,
                                  input logic [15:0] t, input logic p, input int k);
        checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
        checkOutput({tag, "_data"},  32'(outData),  32'(frameByte(x, y, t, p, k)));
        checkOutput({tag, "_last"},  32'(outLast),  32'(k == 6));
    endtask

    initial begin
        // Reset state.
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        rstN = 1'b0;
        tick;
        tick;
        checkOutput("rst_valid", 32'(outValid),  32'd0);
        checkOutput("rst_last",  32'(outLast),   32'd0);
        checkOutput("rst_data",  32'(outData),   32'h00);
        checkOutput("rst_level", 32'(fifoLevel), 32'd0);
        checkOutput("rst_drop",  32'(dropCount), 32'd0);
        rstN = 1'b1;
        tick;

        // Single event, p=1, with the hand-computed byte sequence.
        t1Exp = '{8'hA1, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        applyStimulus(1'b1, 16'h1234, 16'h5678, 16'h9ABC, 1'b1, 1'b1);
        tick;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        checkOutput("t1_level_after_push", 32'(fifoLevel), 32'd1);
        checkOutput("t1_valid_early",      32'(outValid),  32'd0);
        tick;
        for (int k = 0; k < 7; k++) begin
            checkOutput("t1_valid", 32'(outValid), 32'd1);
            checkOutput("t1_data",  32'(outData),  32'(t1Exp[k]));
            checkOutput("t1_last",  32'(outLast),  32'(k == 6));
            tick;
        end
        checkOutput("t1_idle_valid", 32'(outValid),  32'd0);
        checkOutput("t1_idle_level", 32'(fifoLevel), 32'd0);

        // Back-pressure with ready pattern 1,0,0 repeating, p=0.
        applyStimulus(1'b1, 16'h1234, 16'h5678, 16'h9ABC, 1'b0, 1'b0);
        tick;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick;
        checkOutput("t2_header", 32'(outData), 32'hA0);
        modelIdx = 0;
        cyc      = 0;
        while (modelIdx < 7 && cyc < 40) begin
            checkFrameByte("t2_byte", 16'h1234, 16'h5678, 16'h9ABC, 1'b0, modelIdx);
            rdy      = (cyc % 3 == 0);
            outReady = rdy;
            tick;
            if (rdy) modelIdx++;
            cyc++;
        end
        checkOutput("t2_complete", 32'(modelIdx), 32'd7);
        checkOutput("t2_idle",     32'(outValid), 32'd0);
        outReady = 1'b1;

        // Back-to-back frames: three events on consecutive cycles.
        e3X = '{16'h0001, 16'h1111, 16'hABCD};
        e3Y = '{16'h0002, 16'h2222, 16'hEF01};
        e3T = '{16'h0003, 16'h3333, 16'h2345};
        e3P = '{1'b1, 1'b0, 1'b1};
        for (int n = 0; n < 22; n++) begin
            if (n < 3) applyStimulus(1'b1, e3X[n], e3Y[n], e3T[n], e3P[n], 1'b1);
            else       applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
            tick;
            if (n >= 1) begin
                checkFrameByte("t3_byte", e3X[(n-1)/7], e3Y[(n-1)/7], e3T[(n-1)/7],
                               e3P[(n-1)/7], (n-1) % 7);
            end
        end
        checkOutput("t3_drop", 32'(dropCount), 32'd0);
        tick;
        checkOutput("t3_idle", 32'(outValid), 32'd0);

        // Overflow: ten events with out_ready low.
        for (int i = 0; i < 10; i++) begin
            ovX[i] = 16'(32'h0100 + i);
            ovY[i] = 16'(32'h0200 + i);
            ovT[i] = 16'(32'h0300 + i);
            ovP[i] = i[0];
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, ovX[i], ovY[i], ovT[i], ovP[i], 1'b0);
            tick;
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        checkOutput("t4_level", 32'(fifoLevel), 32'd4);
        checkOutput("t4_drop",  32'(dropCount), 32'd5);
        checkFrameByte("t4_held", ovX[0], ovY[0], ovT[0], ovP[0], 0);
        outReady = 1'b1;
        for (int j = 0; j < 35; j++) begin
            checkFrameByte("t4_drain", ovX[j/7], ovY[j/7], ovT[j/7], ovP[j/7], j % 7);
            tick;
        end
        checkOutput("t4_idle_valid", 32'(outValid),  32'd0);
        checkOutput("t4_idle_level", 32'(fifoLevel), 32'd0);

        // Drop saturation: 310 events, 305 of them dropped.
        for (int i = 0; i < 310; i++) begin
            applyStimulus(1'b1, 16'(32'h5000 + i), 16'(32'h6000 + i), 16'(32'h7000 + i),
                          i[0], 1'b0);
            tick;
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        checkOutput("t5_drop_sat", 32'(dropCount), 32'd255);
        checkOutput("t5_level",    32'(fifoLevel), 32'd4);
        repeat (6) tick;
        checkFrameByte("t5_lastbyte", 16'h5000, 16'h6000, 16'h7000, 1'b0, 6);
        // Push in the same cycle as the last-byte handshake with the FIFO full.
        applyStimulus(1'b1, 16'hDEAD, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1);
        tick;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        checkOutput("t5_pushpop_level", 32'(fifoLevel), 32'd4);
        checkOutput("t5_pushpop_drop",  32'(dropCount), 32'd255);
        for (int j = 0; j < 35; j++) begin
            f = j / 7;
            if (f < 4) begin
                checkFrameByte("t5_drain", 16'(32'h5001 + f), 16'(32'h6001 + f),
                               16'(32'h7001 + f), ~f[0], j % 7);
            end else begin
                checkFrameByte("t5_pushed", 16'hDEAD, 16'hBEEF, 16'hCAFE, 1'b1, j % 7);
            end
            tick;
        end
        checkOutput("t5_idle", 32'(outValid), 32'd0);

        // Mid-frame reset during byte 3.
        applyStimulus(1'b1, 16'h0BAD, 16'hF00D, 16'h1357, 1'b0, 1'b1);
        tick;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        repeat (4) tick;
        checkFrameByte("t6_byte3", 16'h0BAD, 16'hF00D, 16'h1357, 1'b0, 3);
        rstN = 1'b0;
        tick;
        checkOutput("t6_rst_valid", 32'(outValid),  32'd0);
        checkOutput("t6_rst_level", 32'(fifoLevel), 32'd0);
        checkOutput("t6_rst_drop",  32'(dropCount), 32'd0);
        checkOutput("t6_rst_data",  32'(outData),   32'h00);
        rstN = 1'b1;
        applyStimulus(1'b1, 16'h2468, 16'hACE0, 16'hFFFF, 1'b1, 1'b1);
        tick;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        checkOutput("t6_level", 32'(fifoLevel), 32'd1);
        tick;
        for (int k = 0; k < 7; k++) begin
            checkFrameByte("t6_frame", 16'h2468, 16'hACE0, 16'hFFFF, 1'b1, k);
            tick;
        end
        checkOutput("t6_idle", 32'(outValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/event_byte_serializer.md
# event_byte_serializer

Downstream of the event filter stage. Accepts filtered DVS events (16-bit x, y, t plus polarity) one per clock without back-pressure and buffers them in a small FIFO. Each event is emitted as a 7-byte frame on an 8-bit valid/ready byte stream for the chip's narrow output pins. Events arriving while the FIFO is full are dropped and counted.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- SYNC, 8'hA0: header marker; bit 0 is ignored and replaced by polarity.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ev_valid  in  1  event present this cycle; no ready is returned.
- ev_x  in  16  event x coordinate.
- ev_y  in  16  event y coordinate.
- ev_t  in  16  event timestamp.
- ev_p  in  1  event polarity.
- out_data  out  8  current frame byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte.
- out_last  out  1  out_data is byte 6 of the frame.
- fifo_level  out  $clog2(DEPTH)+1  number of occupied FIFO entries.
- drop_count  out  8  events dropped because the FIFO was full; saturates at 255.

## Operation
- **FIFO.** Each entry is 49 bits, {p, x, y, t}.
  - Write: ev_valid=1 and (not full, or a pop occurs in the same cycle).
  - Drop: ev_valid=1, FIFO full, and no pop in the same cycle. A drop increments drop_count, saturating at 8'hFF.
- **Frame byte order.**
  - Byte 0: {SYNC[7:1], p}.
  - Bytes 1–6: x[15:8], x[7:0], y[15:8], y[7:0], t[15:8], t[7:0].
- **State machine: IDLE, SEND.**
  - IDLE to SEND when FIFO is non-empty. Pop the head, load it into the 49-bit frame register, set byte index to 0.
  - In SEND, on a handshake (out_valid & out_ready) with index < 6: index increments.
  - On a handshake with index = 6 and FIFO non-empty: pop and load the next event, index returns to 0, stay in SEND. No bubble between frames.
  - On a handshake with index = 6 and FIFO empty: go to IDLE.
- **Output behaviour.**
  - out_valid = 1 exactly in SEND.
  - out_last = 1 exactly when SEND and index = 6.
  - While out_valid=1 and out_ready=0, out_data, out_last and the frame register hold stable.
- **Simultaneous push and pop.** fifo_level is unchanged, and the written entry lands behind the popped one.
- **Reset.** Aborts any frame in flight and takes effect in the same cycle regardless of handshake state.

## Timing
- **Reset values:**
  - out_valid=0, out_last=0, out_data=8'h00
  - fifo_level=0, drop_count=0
  - state=IDLE, FIFO pointers=0
- **Latency.** An event sampled at edge E (FIFO empty, IDLE) has fifo_level=1 after E. At edge E+1 it is popped, and out_valid=1 with the header byte is visible after E+1. Minimum input-to-header latency is 2 edges.
- **Outputs.** All outputs are registered; no combinational path from ev_* or out_ready to any output.
- **Throughput.** With out_ready held high, one frame takes 7 cycles. Sustained capacity is 1 event per 7 cycles; excess input beyond the buffered DEPTH entries is dropped.
- **fifo_level.** Reflects the post-edge occupancy, 0..DEPTH. The pointers wrap modulo DEPTH; full/empty are distinguished by the extra level bit.

## Test plan
- **Single event.** After reset, ev_valid=1 for one cycle with x=16'h1234, y=16'h5678, t=16'h9ABC, p=1, and out_ready=1.
  - Required: out_data sequence A1,12,34,56,78,9A,BC on consecutive cycles starting 2 edges after input.
  - out_last is high only on BC; then out_valid=0 and fifo_level=0.
- **Back-pressure.** Same event with p=0 and out_ready toggling 1,0,0,1,…
  - Required: the byte sequence starts with A0; each byte holds stable across the stalled cycles; no byte is skipped or duplicated.
- **Back-to-back frames.** Three events on consecutive cycles, out_ready=1.
  - Required: 21 consecutive valid bytes with no bubble; out_last on bytes 7, 14 and 21; drop_count=0.
- **Overflow.** DEPTH=4, out_ready=0, ev_valid=1 for 10 cycles.
  - Required: 1 event in the frame register, fifo_level saturates at 4, drop_count=5.
  - Then out_ready=1: exactly 5 frames emerge, in input order.
- **Drop saturation and push-at-full-with-pop.** Force more than 300 drops.
  - Required: drop_count holds at 255.
  - Fill the FIFO, then assert ev_valid in the same cycle as a last-byte handshake. Required: the event is accepted, fifo_level stays at 4, drop_count unchanged.
- **Mid-frame reset.** Assert rst_n=0 for one cycle during byte 3 of a frame.
  - Required: next cycle out_valid=0, fifo_level=0, drop_count=0.
  - A new event afterwards produces a complete, correct frame.
